// File: rtl/quad_decoder_pkg.sv
// Shared types and the Gray-code step decoder for the quadrature decoder.
package qdec_pkg;

  localparam int QDEC_X1 = 1;
  localparam int QDEC_X2 = 2;
  localparam int QDEC_X4 = 4;

  typedef enum logic [1:0] {
    G00 = 2'b00,
    G01 = 2'b01,
    G11 = 2'b11,
    G10 = 2'b10
  } gray_t;

  typedef struct packed {
    logic legal;
    logic up;
    logic down;
  } qdec_step_t;

  function automatic qdec_step_t qdec_decode(input gray_t prev, input gray_t cur);
    logic [1:0] p;
    logic [1:0] c;
    logic [1:0] d;
    logic       one;
    qdec_step_t r;
    p   = prev;
    c   = cur;
    d   = p ^ c;
    one = (d == 2'b01) || (d == 2'b10);
    r.legal = (d != 2'b11);
    // For a single-bit change, forward motion is exactly old A != new B.
    r.up    = one & (p[1] ^ c[0]);
    r.down  = one & ~(p[1] ^ c[0]);
    return r;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder pin/control inputs and decoded outputs of quad_decoder.
interface quad_decoder_if #(
  parameter int CNT_W = 10,
  parameter int OUT_W = 8
);
  logic             a;
  logic             b;
  logic             clr;
  logic             err_clr;
  logic [CNT_W-1:0] count_raw;
  logic [OUT_W-1:0] count_out;
  logic             dir;
  logic             step;
  logic             err;
  logic [CNT_W-1:0] vel;
  logic             vel_valid;

  modport master (
    output a, b, clr, err_clr,
    input  count_raw, count_out, dir, step, err, vel, vel_valid
  );

  modport slave (
    input  a, b, clr, err_clr,
    output count_raw, count_out, dir, step, err, vel, vel_valid
  );
endinterface

// File: rtl/quad_decoder_filter.sv
// Per-channel pin synchroniser followed by a FILT_LEN-cycle stability filter.
module qdec_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_filt,
  output logic o_qual
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_vld;
  logic [CW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   r_qual;
  logic                   w_sync;
  logic                   w_vld;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_vld  = r_vld[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_vld  <= '0;
      r_cnt  <= '0;
      r_filt <= 1'b0;
      r_qual <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_vld  <= {r_vld[SYNC_STAGES-2:0], 1'b1};
      if (w_sync != r_filt) begin
        if (r_cnt == CNT_TOP) begin
          r_filt <= w_sync;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
      // Qualified once real pin data has reached the filter and the output agrees with it.
      r_qual <= r_qual | (w_vld & (w_sync == r_filt));
    end
  end

  assign o_filt = r_filt;
  assign o_qual = r_qual;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: filtered A/B, x1/x2/x4 position counter, error flag.
// Define QDEC_VELOCITY_EN to build the windowed velocity measurement.
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int CNT_W       = 10,
  parameter int OUT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int MODE        = 4,
  parameter int WRAP        = 1,
  parameter int VEL_WIN_W   = 16
) (
  input logic           clk,
  input logic           reset,
  quad_decoder_if.slave bus
);

  if (!(MODE == QDEC_X1 || MODE == QDEC_X2 || MODE == QDEC_X4) ||
      CNT_W < OUT_W || SYNC_STAGES < 2 || FILT_LEN < 1 || VEL_WIN_W < 1) begin : g_bad_cfg
    $error("quad_decoder: unsupported parameter set");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_a, w_b, w_qa, w_qb;
  logic [1:0]       w_cbits, w_pbits;
  gray_t            w_cur, r_prev, w_prev_nxt;
  qdec_step_t       w_dec;
  logic             w_sel, w_up, w_dn, w_illegal;
  logic             r_primed, w_primed_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_step;
  logic             r_err, w_err_nxt;

  qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .rst_n(reset), .i_pin(bus.a), .o_filt(w_a), .o_qual(w_qa)
  );

  qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .rst_n(reset), .i_pin(bus.b), .o_filt(w_b), .o_qual(w_qb)
  );

  always_comb begin
    w_cbits = {w_a, w_b};
    w_cur   = gray_t'(w_cbits);
    w_pbits = r_prev;
    w_dec   = qdec_decode(r_prev, w_cur);

    w_sel = 1'b0;
    if (MODE == QDEC_X4) begin
      w_sel = 1'b1;
    end else if (MODE == QDEC_X2) begin
      w_sel = w_pbits[1] ^ w_cbits[1];
    end else begin
      w_sel = (w_pbits == 2'b10 && w_cbits == 2'b00) ||
              (w_pbits == 2'b00 && w_cbits == 2'b10);
    end

    w_up      = r_primed & w_dec.legal & w_dec.up & w_sel;
    w_dn      = r_primed & w_dec.legal & w_dec.down & w_sel;
    w_illegal = r_primed & ~w_dec.legal;

    // The priming cycle only loads prev_state; counting starts from the following cycle.
    w_primed_nxt = r_primed | (w_qa & w_qb);
    w_prev_nxt   = w_primed_nxt ? w_cur : r_prev;

    w_count_nxt = r_count;
    if (w_up) begin
      if (WRAP != 0 || r_count != CNT_MAX) w_count_nxt = r_count + CNT_W'(1);
    end else if (w_dn) begin
      if (WRAP != 0 || r_count != '0) w_count_nxt = r_count - CNT_W'(1);
    end
    if (bus.clr) w_count_nxt = '0;

    w_dir_nxt = (w_up | w_dn) ? w_up : r_dir;
    w_err_nxt = w_illegal | (r_err & ~bus.err_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev   <= G00;
      r_primed <= 1'b0;
      r_count  <= '0;
      r_dir    <= 1'b0;
      r_step   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_prev   <= w_prev_nxt;
      r_primed <= w_primed_nxt;
      r_count  <= w_count_nxt;
      r_dir    <= w_dir_nxt;
      r_step   <= w_up | w_dn;
      r_err    <= w_err_nxt;
    end
  end

  assign bus.count_raw = r_count;
  assign bus.count_out = r_count[CNT_W-1 -: OUT_W];
  assign bus.dir       = r_dir;
  assign bus.step      = r_step;
  assign bus.err       = r_err;

`ifdef QDEC_VELOCITY_EN
  localparam logic signed [CNT_W-1:0] ACC_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic signed [CNT_W-1:0] ACC_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] ACC_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  logic [VEL_WIN_W-1:0]    r_win;
  logic signed [CNT_W-1:0] r_acc, r_vel, w_acc_sum;
  logic                    r_vel_valid, w_term;

  always_comb begin
    w_term    = &r_win;
    w_acc_sum = r_acc;
    if (w_up && r_acc != ACC_MAX) begin
      w_acc_sum = r_acc + ACC_ONE;
    end else if (w_dn && r_acc != ACC_MIN) begin
      w_acc_sum = r_acc - ACC_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win       <= '0;
      r_acc       <= '0;
      r_vel       <= '0;
      r_vel_valid <= 1'b0;
    end else begin
      r_win       <= r_win + VEL_WIN_W'(1);
      r_vel_valid <= w_term;
      if (w_term) begin
        r_vel <= w_acc_sum;
        r_acc <= '0;
      end else begin
        r_acc <= w_acc_sum;
      end
    end
  end

  assign bus.vel       = r_vel;
  assign bus.vel_valid = r_vel_valid;
`else
  assign bus.vel       = '0;
  assign bus.vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: x4 wrap DUT plus x1 wrap and x1 saturating DUTs on shared pins.
module tb_quad_decoder;

  localparam int CNT_W = 10;
  localparam int OUT_W = 8;
  localparam int MODV  = 1 << CNT_W;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic pa, pb, pclr, perr_clr;

  always #5 clk = ~clk;

  quad_decoder_if #(.CNT_W(CNT_W), .OUT_W(OUT_W)) bus4 ();
  quad_decoder_if #(.CNT_W(CNT_W), .OUT_W(OUT_W)) bus1w ();
  quad_decoder_if #(.CNT_W(CNT_W), .OUT_W(OUT_W)) bus1s ();

  assign bus4.a  = pa;  assign bus4.b  = pb;  assign bus4.clr  = pclr;  assign bus4.err_clr  = perr_clr;
  assign bus1w.a = pa;  assign bus1w.b = pb;  assign bus1w.clr = pclr;  assign bus1w.err_clr = perr_clr;
  assign bus1s.a = pa;  assign bus1s.b = pb;  assign bus1s.clr = pclr;  assign bus1s.err_clr = perr_clr;

  quad_decoder #(.CNT_W(CNT_W), .OUT_W(OUT_W), .SYNC_STAGES(2), .FILT_LEN(4),
                 .MODE(4), .WRAP(1), .VEL_WIN_W(6)) u_dut (
    .clk(clk), .reset(reset), .bus(bus4)
  );
  quad_decoder #(.CNT_W(CNT_W), .OUT_W(OUT_W), .SYNC_STAGES(2), .FILT_LEN(4),
                 .MODE(1), .WRAP(1), .VEL_WIN_W(6)) u_x1w (
    .clk(clk), .reset(reset), .bus(bus1w)
  );
  quad_decoder #(.CNT_W(CNT_W), .OUT_W(OUT_W), .SYNC_STAGES(2), .FILT_LEN(4),
                 .MODE(1), .WRAP(0), .VEL_WIN_W(6)) u_x1s (
    .clk(clk), .reset(reset), .bus(bus1s)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  int n_st_w  = 0;
  int n_st_s  = 0;
  logic vel_seen = 1'b0;
  logic [CNT_W:0] sb[$];
  logic [CNT_W:0] obs_q[$];
`ifdef QDEC_VELOCITY_EN
  int n_vv = 0;
`endif

  // Monitor: records every main-DUT step and counts x1 steps.
  always @(negedge clk) begin
    if (reset) begin
      if (bus4.step) obs_q.push_back({bus4.dir, bus4.count_raw});
      if (bus1w.step) n_st_w++;
      if (bus1s.step) n_st_s++;
      if (bus4.vel_valid || bus4.vel != '0) vel_seen = 1'b1;
`ifdef QDEC_VELOCITY_EN
      if (bus4.vel_valid) n_vv++;
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    chk({tag, "_nsteps"}, obs_q.size(), sb.size());
    while (obs_q.size() != 0 && sb.size() != 0)
      chk({tag, "_step"}, obs_q.pop_front(), sb.pop_front());
    obs_q.delete();
    sb.delete();
  endtask

  // Called on a negedge; side 1 = clr, 2 = err_clr asserted over the step edge.
  task automatic move(input logic na, input logic nb, input int delta, input int side,
                      input string tag);
    pa = na;
    pb = nb;
    if (delta != 0) begin
      exp_cnt = (exp_cnt + delta + MODV) % MODV;
      if (side == 1) exp_cnt = 0;
      sb.push_back({delta > 0, CNT_W'(exp_cnt)});
    end
    repeat (6) @(negedge clk);
    chk({tag, "_early"}, bus4.step, 0);
    if (side == 1) pclr = 1'b1;
    if (side == 2) perr_clr = 1'b1;
    @(negedge clk);
    pclr     = 1'b0;
    perr_clr = 1'b0;
    chk({tag, "_step"}, bus4.step, delta != 0);
    chk({tag, "_count"}, bus4.count_raw, exp_cnt);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n_w0, n_s0;
    pa = 1'b1; pb = 1'b1; pclr = 1'b0; perr_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_count", bus4.count_raw, 0);
    chk("rst_count_out", bus4.count_out, 0);
    chk("rst_dir", bus4.dir, 0);
    chk("rst_step", bus4.step, 0);
    chk("rst_err", bus4.err, 0);
    chk("rst_vel", bus4.vel, 0);
    chk("rst_vel_valid", bus4.vel_valid, 0);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("prime_count", bus4.count_raw, 0);
    chk("prime_err", bus4.err, 0);
    drain("prime");

    move(1'b1, 1'b0, 1, 0, "fwd1");
    move(1'b0, 1'b0, 1, 0, "fwd2");
    move(1'b0, 1'b1, 1, 0, "fwd3");
    move(1'b1, 1'b1, 1, 0, "fwd4");
    chk("fwd_count_out", bus4.count_out, 1);
    chk("fwd_dir", bus4.dir, 1);
    drain("fwd");

    move(1'b1, 1'b0, 1, 0, "to5");
    move(1'b0, 1'b0, 1, 1, "clr_step");
    chk("clr_dir", bus4.dir, 1);
    drain("clr");

    pa = 1'b1;
    repeat (3) @(negedge clk);
    pa = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch3_count", bus4.count_raw, exp_cnt);
    drain("glitch3");

    sb.push_back({1'b0, CNT_W'(MODV - 1)});
    sb.push_back({1'b1, CNT_W'(0)});
    pa = 1'b1;
    repeat (4) @(negedge clk);
    pa = 1'b0;
    repeat (12) @(negedge clk);
    chk("pulse4_count", bus4.count_raw, 0);
    drain("pulse4");

    move(1'b1, 1'b1, 0, 0, "ill1");
    chk("ill1_err", bus4.err, 1);
    perr_clr = 1'b1;
    @(negedge clk);
    perr_clr = 1'b0;
    chk("err_clr", bus4.err, 0);
    move(1'b0, 1'b0, 0, 2, "ill2");
    chk("ill2_err_held", bus4.err, 1);
    drain("illegal");

    pclr = 1'b1;
    @(negedge clk);
    pclr = 1'b0;
    exp_cnt = 0;
    n_w0 = n_st_w;
    n_s0 = n_st_s;
    move(1'b1, 1'b0, -1, 0, "rev1");
    move(1'b1, 1'b1, -1, 0, "rev2");
    move(1'b0, 1'b1, -1, 0, "rev3");
    move(1'b0, 1'b0, -1, 0, "rev4");
    chk("rev_count_out", bus4.count_out, 255);
    chk("rev_dir", bus4.dir, 0);
    chk("x1w_count", bus1w.count_raw, MODV - 1);
    chk("x1w_steps", n_st_w - n_w0, 1);
    chk("x1w_dir", bus1w.dir, 0);
    chk("x1s_count", bus1s.count_raw, 0);
    chk("x1s_steps", n_st_s - n_s0, 1);
    chk("x1s_dir", bus1s.dir, 0);
    drain("rev");

`ifdef QDEC_VELOCITY_EN
    begin
      int t, pos, nv0, d;
      logic [1:0] gseq [4];
      gseq = '{2'b00, 2'b01, 2'b11, 2'b10};
      t = 0;
      while (!bus4.vel_valid && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("vel_sync_found", bus4.vel_valid, 1);
      @(negedge clk);
      nv0 = n_vv;
      pos = 0;
      for (int i = 0; i < 13; i++) begin
        d = (i < 10) ? 1 : -1;
        pos = (pos + d + 4) % 4;
        {pa, pb} = gseq[pos];
        exp_cnt = (exp_cnt + d + MODV) % MODV;
        sb.push_back({d > 0, CNT_W'(exp_cnt)});
        repeat (4) @(negedge clk);
      end
      t = 0;
      while (!bus4.vel_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("vel_valid_pulse", bus4.vel_valid, 1);
      chk("vel_value", bus4.vel, 7);
      @(negedge clk);
      chk("vel_valid_width", bus4.vel_valid, 0);
      chk("vel_valid_count", n_vv - nv0, 1);
      drain("vel");
    end
`else
    repeat (70) @(negedge clk);
    chk("vel_tied_seen", vel_seen, 0);
    chk("vel_tied", bus4.vel, 0);
    chk("vel_valid_tied", bus4.vel_valid, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
